// File: rtl/mips_pkg.sv
// mips_pkg: shared constants, field positions and state encoding for the R-type sequencer
package mips_pkg;
  localparam logic [5:0] OPCODE_RTYPE = 6'd0;
  localparam logic [5:0] FUNCT_SLL    = 6'd0;
  localparam logic [5:0] FUNCT_SRL    = 6'd2;
  localparam logic [5:0] FUNCT_SRA    = 6'd3;
  localparam logic [5:0] FUNCT_ADD    = 6'd32;
  localparam logic [5:0] FUNCT_ADDU   = 6'd33;
  localparam logic [5:0] FUNCT_SUB    = 6'd34;
  localparam logic [5:0] FUNCT_AND    = 6'd36;
  localparam logic [5:0] FUNCT_OR     = 6'd37;
  localparam logic [5:0] FUNCT_SLTU   = 6'd43;
  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;
  localparam int FN_LSB = 0;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_RESP = 3'd4
  } seq_state_t;
endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational R-type ALU
// ports: funct/shamt select the operation, a=rs operand, b=rt operand,
//        y=result (0 when unsupported), illegal_funct=funct not supported
module mips_alu
  import mips_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              illegal_funct
);
  always_comb begin
    y = '0;
    illegal_funct = 1'b0;
    case (funct)
      FUNCT_SLL:  y = b << shamt;
      FUNCT_SRL:  y = b >> shamt;
      FUNCT_SRA:  y = $signed(b) >>> shamt;
      FUNCT_ADD:  y = a + b;
      FUNCT_ADDU: y = a + b;
      FUNCT_SUB:  y = a - b;
      FUNCT_AND:  y = a & b;
      FUNCT_OR:   y = a | b;
      FUNCT_SLTU: y = {{(DATA_W-1){1'b0}}, a < b};
      default:    illegal_funct = 1'b1;
    endcase
  end
endmodule

// File: rtl/mips_rtype_sequencer.sv
// mips_rtype_sequencer: multi-cycle read/execute/write-back controller for R-type instructions
// ports: instr_valid/instr_ready/instruction = instruction handshake,
//        rf_* = register file read (combinational) and write (one-cycle strobe),
//        result/illegal/result_valid/result_ready = response handshake,
//        retired_count = completed instructions, wrapping
module mips_rtype_sequencer
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instruction,
  output logic [4:0]        rf_rs_addr,
  output logic [4:0]        rf_rt_addr,
  input  logic [DATA_W-1:0] rf_rs_data,
  input  logic [DATA_W-1:0] rf_rt_data,
  output logic              rf_wr_en,
  output logic [4:0]        rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  input  logic              result_ready,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_count
);
  seq_state_t state;
  logic [31:0] instr_q;
  logic [DATA_W-1:0] rs_q, rt_q, alu_y;
  logic alu_bad, op_bad;
  assign rf_rs_addr = instr_q[RS_LSB +: 5];
  assign rf_rt_addr = instr_q[RT_LSB +: 5];
  assign rf_wr_addr = instr_q[RD_LSB +: 5];
  assign rf_wr_data = result;
  assign op_bad = instr_q[OP_LSB +: 6] != OPCODE_RTYPE;
  assign instr_ready = state == S_IDLE;
  assign result_valid = state == S_RESP;
  assign rf_wr_en = state == S_WB && !illegal && rf_wr_addr != 5'd0;
  mips_alu #(.DATA_W(DATA_W)) u_alu (
    .funct(instr_q[FN_LSB +: 6]),
    .shamt(instr_q[SH_LSB +: 5]),
    .a(rs_q),
    .b(rt_q),
    .y(alu_y),
    .illegal_funct(alu_bad)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      instr_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      result <= '0;
      illegal <= 1'b0;
      retired_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (instr_valid) begin
          instr_q <= instruction;
          state <= S_READ;
        end
        S_READ: begin
          rs_q <= rf_rs_data;
          rt_q <= rf_rt_data;
          state <= S_EXEC;
        end
        S_EXEC: begin
          // a bad opcode must also zero the result even when funct happens to decode
          result <= (op_bad || alu_bad) ? '0 : alu_y;
          illegal <= op_bad || alu_bad;
          state <= S_WB;
        end
        S_WB: begin
          retired_count <= retired_count + CNT_W'(1);
          state <= S_RESP;
        end
        S_RESP: if (result_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_rtype_sequencer.sv
// tb_mips_rtype_sequencer: scoreboard bench with a behavioural register file
module tb_mips_rtype_sequencer;
  import mips_pkg::*;
  localparam int DATA_W = 32;
  localparam int CNT_W = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic instr_valid = 1'b0;
  logic instr_ready;
  logic [31:0] instruction = '0;
  logic [4:0] rf_rs_addr, rf_rt_addr, rf_wr_addr;
  logic [DATA_W-1:0] rf_rs_data, rf_rt_data, rf_wr_data, result;
  logic rf_wr_en, result_valid, illegal;
  logic result_ready = 1'b1;
  logic [CNT_W-1:0] retired_count;
  logic [31:0] rf [32] = '{default: '0};
  logic pl_en = 1'b0;
  logic [4:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  typedef struct {
    logic wr;
    logic [4:0] addr;
    logic [31:0] data;
    logic ill;
    logic [CNT_W-1:0] cnt;
    int acc;
  } exp_t;
  exp_t q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  bit wseen = 0;
  bit vseen = 0;

  mips_rtype_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instruction(instruction),
    .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .illegal(illegal), .retired_count(retired_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign rf_rs_data = rf[rf_rs_addr];
  assign rf_rt_data = rf[rf_rt_addr];
  always @(posedge clk) begin
    if (rf_wr_en) rf[rf_wr_addr] <= rf_wr_data;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rf_wr_en) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_write: addr %0d data %h, expected no write", rf_wr_addr, rf_wr_data);
      end else begin
        chk("wr_allowed", 32'(rf_wr_en), 32'(q[0].wr));
        chk("wr_addr", 32'(rf_wr_addr), 32'(q[0].addr));
        chk("wr_data", rf_wr_data, q[0].data);
        chk("wr_cycle", cyc, q[0].acc + 3);
        wseen = 1;
      end
    end
    if (result_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: result %h, expected none", result);
      end else begin
        if (!vseen) chk("valid_cycle", cyc, q[0].acc + 4);
        vseen = 1;
        if (result_ready) begin
          chk("result", result, q[0].data);
          chk("illegal", 32'(illegal), 32'(q[0].ill));
          chk("retired_count", 32'(retired_count), 32'(q[0].cnt));
          chk("write_seen", 32'(wseen), 32'(q[0].wr));
          void'(q.pop_front());
          wseen = 0;
          vseen = 0;
        end
      end
    end
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic issue(input logic [31:0] ins, input bit push, input logic [31:0] res, input logic ill);
    int n = 0;
    while (!instr_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: instr_ready %b after %0d cycles, expected 1", instr_ready, n);
      return;
    end
    instr_valid = 1'b1;
    instruction = ins;
    if (push) begin
      exp_cnt++;
      q.push_back('{!ill && ins[15:11] != 5'd0, ins[15:11], res, ill, exp_cnt, cyc});
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(q.size() == 0 && instr_ready) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: %0d results pending, expected 0", q.size());
    end
  endtask

  task automatic set_reg(input logic [4:0] a, input logic [31:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en = 1'b1;
    @(posedge clk);
    #1 pl_en = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_instr_ready", 32'(instr_ready), 1);
    chk("rst_result_valid", 32'(result_valid), 0);
    chk("rst_retired", 32'(retired_count), 0);
    chk("rst_wr_en", 32'(rf_wr_en), 0);
    chk("rst_result", result, 0);
    chk("rst_illegal", 32'(illegal), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    set_reg(1, 5);
    set_reg(2, 7);
    issue(32'h00221820, 1, 32'd12, 0);
    wait_idle();
    set_reg(2, 32'h80000000);
    issue(enc(0, 0, 2, 4, 4, FUNCT_SRA), 1, 32'hF8000000, 0);
    issue(enc(0, 0, 2, 5, 4, FUNCT_SRL), 1, 32'h08000000, 0);
    wait_idle();
    set_reg(1, 1);
    set_reg(2, 32'hFFFFFFFF);
    issue(enc(0, 1, 2, 6, 0, FUNCT_SLTU), 1, 32'd1, 0);
    wait_idle();
    set_reg(1, 3);
    set_reg(2, 5);
    issue(enc(0, 1, 2, 7, 0, FUNCT_SUB), 1, 32'hFFFFFFFE, 0);
    issue(enc(0, 1, 2, 8, 0, 6'd8), 1, 32'd0, 1);
    issue(enc(6'h23, 1, 2, 8, 0, FUNCT_ADD), 1, 32'd0, 1);
    issue(enc(0, 1, 2, 0, 0, FUNCT_ADD), 1, 32'd8, 0);
    issue(enc(0, 1, 2, 1, 0, FUNCT_ADD), 1, 32'd8, 0);
    issue(enc(0, 1, 1, 9, 0, FUNCT_ADDU), 1, 32'd16, 0);
    issue(enc(0, 0, 2, 10, 0, FUNCT_SLL), 1, 32'd5, 0);
    issue(enc(0, 0, 2, 13, 3, FUNCT_SLL), 1, 32'd40, 0);
    issue(enc(0, 1, 2, 11, 0, FUNCT_AND), 1, 32'd0, 0);
    issue(enc(0, 1, 2, 12, 0, FUNCT_OR), 1, 32'd13, 0);
    wait_idle();
    result_ready = 1'b0;
    issue(enc(0, 1, 2, 14, 0, FUNCT_OR), 1, 32'd13, 0);
    for (int i = 0; i < 10 && !result_valid; i++) begin
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 10; i++) begin
      instr_valid = 1'b1;
      instruction = enc(0, 1, 2, 15, 0, FUNCT_SUB);
      @(posedge clk);
      #1;
      chk("hold_instr_ready", 32'(instr_ready), 0);
      chk("hold_result_valid", 32'(result_valid), 1);
      chk("hold_result", result, 32'd13);
    end
    result_ready = 1'b1;
    instr_valid = 1'b0;
    issue(enc(0, 1, 2, 15, 0, FUNCT_SUB), 1, 32'd3, 0);
    wait_idle();
    issue(enc(0, 1, 2, 7, 0, FUNCT_ADD), 0, 32'd0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    exp_cnt = '0;
    chk("midrst_instr_ready", 32'(instr_ready), 1);
    chk("midrst_result_valid", 32'(result_valid), 0);
    chk("midrst_wr_en", 32'(rf_wr_en), 0);
    chk("midrst_retired", 32'(retired_count), 0);
    chk("midrst_result", result, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("midrst_r7_kept", rf[7], 32'hFFFFFFFE);
    issue(enc(0, 1, 2, 16, 0, FUNCT_ADD), 1, 32'd13, 0);
    for (int i = 0; i < 16; i++) issue(enc(0, 1, 2, 17, 0, FUNCT_ADDU), 1, 32'd13, 0);
    wait_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mips_rtype_sequencer.md
Name: mips_rtype_sequencer

Overview:
- Multi-cycle controller that sequences one R-type MIPS instruction at a time through register read, ALU execute and register write-back.
- Sits between an instruction source (valid/ready handshake) and the shared 32x32 register file with combinational read ports and a synchronous write port.
- Replaces the free-running combinational write strobe with a clocked FSM. Reports each result with a valid/ready handshake and counts retired instructions.

Parameters:
- DATA_W, 32, datapath and register width
- CNT_W, 16, width of retired-instruction counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  sequencer can accept an instruction
- instruction  in  32  R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]
- rf_rs_addr  out  5  register file read address 1
- rf_rt_addr  out  5  register file read address 2
- rf_rs_data  in  DATA_W  read data 1, combinational from rf_rs_addr
- rf_rt_data  in  DATA_W  read data 2, combinational from rf_rt_addr
- rf_wr_en  out  1  register file write strobe, one cycle
- rf_wr_addr  out  5  write address (rd)
- rf_wr_data  out  DATA_W  write data
- result  out  DATA_W  ALU result of the last instruction
- result_valid  out  1  result/illegal are valid
- result_ready  in  1  consumer accepts result
- illegal  out  1  last instruction had an unsupported opcode/funct
- retired_count  out  CNT_W  instructions completed, including illegal ones

Behaviour:
- Reset: state IDLE; instruction latch 0; operand registers 0; all outputs 0, except instr_ready=1 once in IDLE.
- States: IDLE, READ, EXEC, WB, RESP.
- IDLE: instr_ready=1. On instr_valid=1, latch the instruction and go to READ. Otherwise stay.
- READ (1 cycle): drive rf_rs_addr/rf_rt_addr from the latch. Register rf_rs_data/rf_rt_data into the operand registers. Go to EXEC.
- EXEC (1 cycle): compute the ALU result from the registered operands. Register result and the illegal flag. Go to WB.
- WB (1 cycle):
  - rf_wr_en=1 only if the instruction is legal and rd != 0.
  - rf_wr_addr=rd; rf_wr_data=result.
  - Increment retired_count. It wraps modulo 2^CNT_W.
  - Go to RESP.
- RESP: result_valid=1; result and illegal held stable. On result_ready=1, go to IDLE. Otherwise stay.
- Latency: instruction accepted at edge N produces the write at edge N+3 and result_valid high from cycle N+3. Minimum issue interval is 5 cycles when result_ready is held at 1.
- instr_ready=0 in every state except IDLE. instr_valid is ignored outside IDLE.
- ALU ops (opcode must be 0):
  - funct 0 sll: rt << shamt
  - funct 2 srl: rt >> shamt, logical
  - funct 3 sra: rt >>> shamt, arithmetic
  - funct 32 add: rs + rt, signed, no overflow trap
  - funct 33 addu: rs + rt
  - funct 34 sub: rs - rt
  - funct 36 and
  - funct 37 or
  - funct 43 sltu: unsigned rs < rt gives 1, else 0, zero-extended
- Illegal: opcode != 0 or funct not in the list above. Then result=0, illegal=1, no register write; the instruction still retires.
- Only the low 5 bits of shamt are used. Shift by 0 passes the operand through.
- rd=0: no write, but result is still reported.
- rd equal to rs or rt: the write happens in WB after the operands were captured in READ, so there is no hazard.
- Back-to-back instruction reading the previous rd: the write completes before the next READ, so the new value is read.
- rst asserted mid-operation: immediate return to IDLE. Any pending write is dropped; result_valid=0; retired_count=0.

Decomposition:
- Package mips_pkg:
  - funct constants: FUNCT_SLL, FUNCT_SRL, FUNCT_SRA, FUNCT_ADD, FUNCT_ADDU, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_SLTU
  - OPCODE_RTYPE
  - state enum seq_state_t
  - field position constants
- One sub-module: mips_alu. Combinational; inputs funct, shamt, a, b; outputs y and illegal_funct. Instantiated in the sequencer.

Test Plan:
- Reset, then R1=5, R2=7 preloaded; add rd=3 (0x00221820) -> rf_wr_en at cycle N+3 with addr 3, data 12; result=12; retired_count=1.
- R2=0x80000000, sra shamt=4, rd=4 -> 0xF8000000. srl with the same inputs -> 0x08000000.
- sltu with R1=1, R2=0xFFFFFFFF -> result 1. sub with R1=3, R2=5 -> 0xFFFFFFFE.
- funct=8 (or opcode=0x23) -> illegal=1, result=0, no rf_wr_en, retired_count still increments. rd=0 add -> no rf_wr_en.
- result_ready held 0 for 10 cycles -> result_valid stays 1, result stable, instr_ready 0. A second instr_valid is not accepted until after release.
- rst pulsed during EXEC -> no write occurs, outputs return to reset values, the next instruction executes normally. Counter preset near 0xFFFF then one retire -> wraps to 0.
